// File: rtl/traffic_light_ctrl.sv
// Two-direction traffic light sequencer with a BCD per-phase seconds countdown
// and a flashing-yellow night mode. All outputs are registered.
module traffic_light_ctrl #(
    parameter int TICK_DIV    = 50000000,
    parameter int GREEN_TIME  = 30,
    parameter int YELLOW_TIME = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause,
    input  logic       night,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [3:0] count_tens,
    output logic [3:0] count_ones
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    localparam logic [3:0] GREEN_TENS  = 4'(GREEN_TIME / 10);
    localparam logic [3:0] GREEN_ONES  = 4'(GREEN_TIME % 10);
    localparam logic [3:0] YELLOW_TENS = 4'(YELLOW_TIME / 10);
    localparam logic [3:0] YELLOW_ONES = 4'(YELLOW_TIME % 10);

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_OFF    = 3'b000;

    if (TICK_DIV < 2) begin : gBadTickDiv
        $error("traffic_light_ctrl: TICK_DIV must be at least 2");
    end
    if (GREEN_TIME < 2 || GREEN_TIME > 99) begin : gBadGreen
        $error("traffic_light_ctrl: GREEN_TIME must be within 2..99");
    end
    if (YELLOW_TIME < 2 || YELLOW_TIME > 99) begin : gBadYellow
        $error("traffic_light_ctrl: YELLOW_TIME must be within 2..99");
    end

    typedef enum logic [2:0] {
        NS_GREEN,
        NS_YELLOW,
        EW_GREEN,
        EW_YELLOW,
        NIGHT
    } state_t;

    state_t           state;
    logic [PRE_W-1:0] prescaler;
    logic             blink;
    logic [3:0]       tens;
    logic [3:0]       ones;
    logic [2:0]       nsLamps;
    logic [2:0]       ewLamps;

    logic preWrap;
    logic lastSecond;

    assign preWrap    = (prescaler == PRE_LAST);
    assign lastSecond = (tens == 4'd0) && (ones == 4'd1);

    function automatic state_t nextPhase(input state_t s);
        case (s)
            NS_GREEN:  return NS_YELLOW;
            NS_YELLOW: return EW_GREEN;
            EW_GREEN:  return EW_YELLOW;
            default:   return NS_GREEN;
        endcase
    endfunction

    function automatic logic isGreen(input state_t s);
        return (s == NS_GREEN) || (s == EW_GREEN);
    endfunction

    function automatic logic [2:0] nsLampsFor(input state_t s);
        case (s)
            NS_GREEN:  return LAMP_GREEN;
            NS_YELLOW: return LAMP_YELLOW;
            default:   return LAMP_RED;
        endcase
    endfunction

    function automatic logic [2:0] ewLampsFor(input state_t s);
        case (s)
            EW_GREEN:  return LAMP_GREEN;
            EW_YELLOW: return LAMP_YELLOW;
            default:   return LAMP_RED;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= NS_GREEN;
            prescaler <= '0;
            blink     <= 1'b0;
            tens      <= GREEN_TENS;
            ones      <= GREEN_ONES;
            nsLamps   <= LAMP_GREEN;
            ewLamps   <= LAMP_RED;
        end else if (night) begin
            if (state != NIGHT) begin
                // Entry starts a fresh blink period so the first tick lights the lamps.
                state     <= NIGHT;
                prescaler <= '0;
                blink     <= 1'b0;
                tens      <= 4'd0;
                ones      <= 4'd0;
                nsLamps   <= LAMP_OFF;
                ewLamps   <= LAMP_OFF;
            end else if (preWrap) begin
                prescaler <= '0;
                blink     <= ~blink;
                nsLamps   <= blink ? LAMP_OFF : LAMP_YELLOW;
                ewLamps   <= blink ? LAMP_OFF : LAMP_YELLOW;
            end else begin
                prescaler <= prescaler + PRE_W'(1);
            end
        end else if (state == NIGHT) begin
            state     <= NS_GREEN;
            prescaler <= '0;
            blink     <= 1'b0;
            tens      <= GREEN_TENS;
            ones      <= GREEN_ONES;
            nsLamps   <= LAMP_GREEN;
            ewLamps   <= LAMP_RED;
        end else if (pause) begin
            prescaler <= prescaler;
        end else if (preWrap) begin
            prescaler <= '0;
            if (lastSecond) begin
                // Lamps and reload switch on the same edge, so no overlap cycles exist.
                state   <= nextPhase(state);
                tens    <= isGreen(nextPhase(state)) ? GREEN_TENS : YELLOW_TENS;
                ones    <= isGreen(nextPhase(state)) ? GREEN_ONES : YELLOW_ONES;
                nsLamps <= nsLampsFor(nextPhase(state));
                ewLamps <= ewLampsFor(nextPhase(state));
            end else if (ones == 4'd0) begin
                ones <= 4'd9;
                tens <= tens - 4'd1;
            end else begin
                ones <= ones - 4'd1;
            end
        end else begin
            prescaler <= prescaler + PRE_W'(1);
        end
    end

    assign ns_light   = nsLamps;
    assign ew_light   = ewLamps;
    assign count_tens = tens;
    assign count_ones = ones;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl with TICK_DIV=4, GREEN_TIME=12, YELLOW_TIME=3.
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pause = 1'b0;
    logic       night = 1'b0;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [3:0] count_tens;
    logic [3:0] count_ones;

    int checks = 0;
    int failures = 0;

    logic [13:0] sb[$];
    logic [13:0] exp;

    // Reference model: decimal seconds remaining, state 0..3 phases, 4 = night.
    int mSt = 0;
    int mPre = 0;
    int mRem = 12;
    bit mBlink = 1'b0;

    traffic_light_ctrl #(
        .TICK_DIV(4),
        .GREEN_TIME(12),
        .YELLOW_TIME(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pause(pause),
        .night(night),
        .ns_light(ns_light),
        .ew_light(ew_light),
        .count_tens(count_tens),
        .count_ones(count_ones)
    );

    always #5 clk = ~clk;

    wire [13:0] obs = {ns_light, ew_light, count_tens, count_ones};

    function automatic logic [13:0] modelOut();
        logic [2:0] n;
        logic [2:0] e;
        case (mSt)
            0: begin n = 3'b001; e = 3'b100; end
            1: begin n = 3'b010; e = 3'b100; end
            2: begin n = 3'b100; e = 3'b001; end
            3: begin n = 3'b100; e = 3'b010; end
            default: begin n = mBlink ? 3'b010 : 3'b000; e = n; end
        endcase
        return {n, e, 4'(mRem / 10), 4'(mRem % 10)};
    endfunction

    task automatic cyc(input logic r, input logic n, input logic p);
        rst = r;
        night = n;
        pause = p;
        if (r) begin
            mSt = 0; mPre = 0; mBlink = 0; mRem = 12;
        end else if (n) begin
            if (mSt != 4) begin
                mSt = 4; mPre = 0; mBlink = 0; mRem = 0;
            end else if (mPre == 3) begin
                mPre = 0; mBlink = ~mBlink;
            end else begin
                mPre++;
            end
        end else if (mSt == 4) begin
            mSt = 0; mRem = 12; mPre = 0; mBlink = 0;
        end else if (!p) begin
            if (mPre == 3) begin
                mPre = 0;
                if (mRem == 1) begin
                    mSt = (mSt + 1) % 4;
                    mRem = (mSt == 0 || mSt == 2) ? 12 : 3;
                end else begin
                    mRem--;
                end
            end else begin
                mPre++;
            end
        end
        sb.push_back(modelOut());
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL reset_sb cyc=%0d got=%h want=%h", i, obs, exp);
            end
        end
        checks++;
        if (obs !== {3'b001, 3'b100, 4'd1, 4'd2}) begin
            failures++;
            $display("FAIL reset_value got=%h want=%h", obs, {3'b001, 3'b100, 4'd1, 4'd2});
        end
    endtask

    task automatic test_free_run();
        for (int i = 1; i <= 48; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL free_run cyc=%0d got=%h want=%h", i, obs, exp);
            end
            if (i == 3 || i == 4 || i == 12 || i == 47 || i == 48) begin
                logic [13:0] want;
                case (i)
                    3:  want = {3'b001, 3'b100, 4'd1, 4'd2};
                    4:  want = {3'b001, 3'b100, 4'd1, 4'd1};
                    12: want = {3'b001, 3'b100, 4'd0, 4'd9};
                    47: want = {3'b001, 3'b100, 4'd0, 4'd1};
                    default: want = {3'b010, 3'b100, 4'd0, 4'd3};
                endcase
                checks++;
                if (obs !== want) begin
                    failures++;
                    $display("FAIL free_run_point cyc=%0d got=%h want=%h", i, obs, want);
                end
            end
        end
    endtask

    task automatic test_full_cycle();
        for (int i = 49; i <= 120; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL full_cycle cyc=%0d got=%h want=%h", i, obs, exp);
            end
            checks++;
            if (ns_light !== 3'b100 && ew_light !== 3'b100) begin
                failures++;
                $display("FAIL conflict cyc=%0d ns=%b ew=%b required one red", i, ns_light, ew_light);
            end
            if (i == 60 || i == 108 || i == 120) begin
                logic [13:0] want;
                case (i)
                    60:  want = {3'b100, 3'b001, 4'd1, 4'd2};
                    108: want = {3'b100, 3'b010, 4'd0, 4'd3};
                    default: want = {3'b001, 3'b100, 4'd1, 4'd2};
                endcase
                checks++;
                if (obs !== want) begin
                    failures++;
                    $display("FAIL phase_edge cyc=%0d got=%h want=%h", i, obs, want);
                end
            end
        end
    endtask

    task automatic test_pause();
        // Reach 0/7 (five ticks), then three more cycles so the pause lands on the tick edge.
        for (int i = 0; i < 23; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL pause_lead cyc=%0d got=%h want=%h", i, obs, exp);
            end
        end
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 1'b1);
            exp = sb.pop_front();
            checks++;
            if (obs !== {3'b001, 3'b100, 4'd0, 4'd7} || obs !== exp) begin
                failures++;
                $display("FAIL pause_hold cyc=%0d got=%h want=%h", i, obs, exp);
            end
        end
        cyc(1'b0, 1'b0, 1'b0);
        exp = sb.pop_front();
        checks++;
        if (obs !== {3'b001, 3'b100, 4'd0, 4'd6} || obs !== exp) begin
            failures++;
            $display("FAIL pause_resume got=%h want=%h", obs, {3'b001, 3'b100, 4'd0, 4'd6});
        end
    endtask

    task automatic test_night();
        cyc(1'b1, 1'b0, 1'b0);
        exp = sb.pop_front();
        for (int i = 0; i < 70; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            exp = sb.pop_front();
        end
        checks++;
        if (ew_light !== 3'b001 || ns_light !== 3'b100) begin
            failures++;
            $display("FAIL night_setup ns=%b ew=%b want ns=100 ew=001", ns_light, ew_light);
        end
        for (int k = 0; k <= 13; k++) begin
            logic [2:0] lamp;
            cyc(1'b0, 1'b1, (k > 0));
            exp = sb.pop_front();
            lamp = (k > 0 && ((k / 4) % 2) == 1) ? 3'b010 : 3'b000;
            checks++;
            if (obs !== {lamp, lamp, 4'd0, 4'd0} || obs !== exp) begin
                failures++;
                $display("FAIL night_blink k=%0d got=%h want=%h", k, obs, {lamp, lamp, 4'd0, 4'd0});
            end
        end
        cyc(1'b0, 1'b0, 1'b0);
        exp = sb.pop_front();
        checks++;
        if (obs !== {3'b001, 3'b100, 4'd1, 4'd2} || obs !== exp) begin
            failures++;
            $display("FAIL night_exit got=%h want=%h", obs, {3'b001, 3'b100, 4'd1, 4'd2});
        end
        // Single-cycle night pulse mid-phase.
        for (int i = 0; i < 9; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            exp = sb.pop_front();
        end
        cyc(1'b0, 1'b1, 1'b0);
        exp = sb.pop_front();
        checks++;
        if (obs !== {3'b000, 3'b000, 4'd0, 4'd0}) begin
            failures++;
            $display("FAIL night_pulse_in got=%h want=%h", obs, {3'b000, 3'b000, 4'd0, 4'd0});
        end
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL night_pulse_out cyc=%0d got=%h want=%h", i, obs, exp);
            end
        end
        checks++;
        if (obs !== {3'b001, 3'b100, 4'd1, 4'd1}) begin
            failures++;
            $display("FAIL night_restart got=%h want=%h", obs, {3'b001, 3'b100, 4'd1, 4'd1});
        end
    endtask

    task automatic test_reset_mid();
        cyc(1'b1, 1'b0, 1'b0);
        exp = sb.pop_front();
        for (int i = 0; i < 117; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            exp = sb.pop_front();
        end
        checks++;
        if (obs !== {3'b100, 3'b010, 4'd0, 4'd1}) begin
            failures++;
            $display("FAIL mid_setup got=%h want=%h", obs, {3'b100, 3'b010, 4'd0, 4'd1});
        end
        cyc(1'b1, 1'b0, 1'b0);
        exp = sb.pop_front();
        checks++;
        if (obs !== {3'b001, 3'b100, 4'd1, 4'd2} || obs !== exp) begin
            failures++;
            $display("FAIL mid_reset got=%h want=%h", obs, {3'b001, 3'b100, 4'd1, 4'd2});
        end
        for (int i = 1; i <= 4; i++) begin
            logic [13:0] want;
            cyc(1'b0, 1'b0, 1'b0);
            exp = sb.pop_front();
            want = (i == 4) ? {3'b001, 3'b100, 4'd1, 4'd1} : {3'b001, 3'b100, 4'd1, 4'd2};
            checks++;
            if (obs !== want || obs !== exp) begin
                failures++;
                $display("FAIL mid_first_tick cyc=%0d got=%h want=%h", i, obs, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_full_cycle();
        test_pause();
        test_night();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
